ifetch_ctrl: RTL and testbench

- Instruction-fetch sequencer for the asynchronous-read instruction ROM.
- Owns the PC and drives the ROM address each cycle.
- Captures returned words with their PCs into a 2-entry queue and hands them to decode over a valid/ready handshake.
- Handles branch/jump redirects, halt requests and fetch faults (misaligned or out-of-range PC).

---
 rtl/ifetch_pkg.sv | 17 +
 rtl/ifetch_queue.sv | 46 ++++
 rtl/ifetch_ctrl.sv | 145 ++++++++++++++
 tb/tb_ifetch_ctrl.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/ifetch_pkg.sv
// Shared state encoding, constants and queue-entry type for the instruction-fetch sequencer.
package ifetch_pkg;

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      HALT  = 2'd1,
      FAULT = 2'd2
   } state_t;

   localparam int unsigned INSTR_BYTES = 4;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } entry_t;

endpackage

// File: rtl/ifetch_queue.sv
// 2-entry synchronous FIFO holding fetched {pc, instr} pairs; head is read combinationally.
// Latency: a push is visible at the head the cycle after it is written.
// Backpressure: caller must not push when full without a simultaneous pop; flush beats push.
module ifetch_queue
   import ifetch_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       flush,
   input  logic       push,
   input  entry_t     push_dat,
   input  logic       pop,
   output logic [1:0] count,
   output entry_t     head_dat
);

   entry_t     mem_q [2];
   logic       rd_ptr_q;
   logic       wr_ptr_q;
   logic [1:0] count_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr_q <= 1'b0;
         wr_ptr_q <= 1'b0;
         count_q  <= 2'd0;
      end else if (flush) begin
         rd_ptr_q <= 1'b0;
         wr_ptr_q <= 1'b0;
         count_q  <= 2'd0;
      end else begin
         if (push) wr_ptr_q <= ~wr_ptr_q;
         if (pop)  rd_ptr_q <= ~rd_ptr_q;
         count_q <= count_q + {1'b0, push} - {1'b0, pop};
      end
   end

   // Payload needs no reset; count_q alone decides validity.
   always_ff @(posedge clk) begin
      if (push && !flush) mem_q[wr_ptr_q] <= push_dat;
   end

   assign count    = count_q;
   assign head_dat = mem_q[rd_ptr_q];

endmodule

// File: rtl/ifetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, drives the async ROM and queues words for decode.
// Latency: word fetched in cycle N appears on out_* in N+1; a redirect target appears 2 cycles later.
// Backpressure: out_valid/out_ready; fetch stalls when the 2-entry queue is full and not popping.
// Optional perf counters are built when IFETCH_PERF_EN is defined.
module ifetch_ctrl
   import ifetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int unsigned IMEM_DEPTH = 256,
   parameter int unsigned QDEPTH     = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_data,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_instr,
   output logic [31:0] out_pc,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   input  logic        halt_req,
   output logic        halted,
   output logic        fault,
   output logic [31:0] fault_pc
`ifdef IFETCH_PERF_EN
  ,output logic [31:0] perf_fetched,
   output logic [31:0] perf_stall,
   output logic [31:0] perf_flush
`endif
);

   localparam logic [1:0]  Q_FULL   = 2'(QDEPTH);
   localparam logic [32:0] PC_LIMIT = 33'(IMEM_DEPTH * INSTR_BYTES);

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] fault_pc_q, fault_pc_d;

   logic [1:0]  count;
   entry_t      head_dat;
   entry_t      push_dat;
   logic        pop;
   logic        push;
   logic        flush;
   logic        redirect_ok;
   logic        redirect_bad;
   logic        room;
   logic        pc_in_range;
   logic        fetch_try;
   logic        range_fault;

   assign pop          = out_valid && out_ready;
   assign redirect_ok  = redirect_valid && (state_q != FAULT);
   assign redirect_bad = redirect_ok && (redirect_pc[1:0] != 2'b00);
   assign room         = (count != Q_FULL) || pop;
   // Widened compare so a wrapped pc_q can never look in range.
   assign pc_in_range  = ({1'b0, pc_q} < PC_LIMIT);
   assign fetch_try    = (state_q == RUN) && !halt_req && !redirect_ok && room;
   assign push         = fetch_try && pc_in_range;
   assign range_fault  = fetch_try && !pc_in_range;
   assign flush        = redirect_ok;
   assign push_dat     = '{pc: pc_q, instr: imem_data};

   ifetch_queue u_queue (
      .clk      (clk),
      .rst_n    (rst_n),
      .flush    (flush),
      .push     (push),
      .push_dat (push_dat),
      .pop      (pop),
      .count    (count),
      .head_dat (head_dat)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= RUN;
         pc_q       <= RESET_PC;
         fault_pc_q <= 32'd0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         fault_pc_q <= fault_pc_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      fault_pc_d = fault_pc_q;
      if (redirect_bad) begin
         state_d    = FAULT;
         fault_pc_d = redirect_pc;
      end else if (redirect_ok) begin
         pc_d    = redirect_pc;
         state_d = halt_req ? HALT : RUN;
      end else if (range_fault) begin
         state_d    = FAULT;
         fault_pc_d = pc_q;
      end else begin
         if (push) pc_d = pc_q + 32'(INSTR_BYTES);
         case (state_q)
            RUN:     if (halt_req)  state_d = HALT;
            HALT:    if (!halt_req) state_d = RUN;
            default: state_d = state_q;
         endcase
      end
   end

   assign imem_addr = pc_q;
   assign out_valid = (count != 2'd0);
   assign out_instr = head_dat.instr;
   assign out_pc    = head_dat.pc;
   assign halted    = (state_q == HALT) && (count == 2'd0);
   assign fault     = (state_q == FAULT);
   assign fault_pc  = fault_pc_q;

`ifdef IFETCH_PERF_EN
   logic [31:0] fetched_q, stall_q, flushed_q;
   logic        stall_cyc;
   logic        flush_hit;

   assign stall_cyc = (state_q == RUN) && (count == Q_FULL) && !pop;
   // Entries discarded by a redirect = count minus the one being popped.
   assign flush_hit = redirect_ok && (count > {1'b0, pop});

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fetched_q <= 32'd0;
         stall_q   <= 32'd0;
         flushed_q <= 32'd0;
      end else begin
         if (push && (fetched_q != 32'hFFFF_FFFF))      fetched_q <= fetched_q + 32'd1;
         if (stall_cyc && (stall_q != 32'hFFFF_FFFF))   stall_q   <= stall_q + 32'd1;
         if (flush_hit && (flushed_q != 32'hFFFF_FFFF)) flushed_q <= flushed_q + 32'd1;
      end
   end

   assign perf_fetched = fetched_q;
   assign perf_stall   = stall_q;
   assign perf_flush   = flushed_q;
`endif

endmodule

// File: tb/tb_ifetch_ctrl.sv
// Self-checking bench for ifetch_ctrl: directed scenarios plus random traffic against a queue-level model.
module tb_ifetch_ctrl;

   localparam int unsigned DEPTH   = 256;
   localparam logic [31:0] RST_PC  = 32'h0000_0000;
   localparam int          M_RUN   = 0;
   localparam int          M_HALT  = 1;
   localparam int          M_FAULT = 2;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } ment_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] imem_addr;
   logic [31:0] imem_data;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] out_instr;
   logic [31:0] out_pc;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = 32'd0;
   logic        halt_req = 1'b0;
   logic        halted;
   logic        fault;
   logic [31:0] fault_pc;
`ifdef IFETCH_PERF_EN
   logic [31:0] perf_fetched, perf_stall, perf_flush;
`endif

   logic [31:0] rom [DEPTH];
   assign imem_data = rom[imem_addr[9:2]];

   always #5 clk = ~clk;

   ifetch_ctrl #(.RESET_PC(RST_PC), .IMEM_DEPTH(DEPTH), .QDEPTH(2)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .imem_addr      (imem_addr),
      .imem_data      (imem_data),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_instr      (out_instr),
      .out_pc         (out_pc),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .halt_req       (halt_req),
      .halted         (halted),
      .fault          (fault),
      .fault_pc       (fault_pc)
`ifdef IFETCH_PERF_EN
     ,.perf_fetched   (perf_fetched),
      .perf_stall     (perf_stall),
      .perf_flush     (perf_flush)
`endif
   );

   int          n_vec = 0;
   int          n_err = 0;

   // Reference model state
   ment_t       mq[$];
   logic [31:0] m_pc;
   int          m_mode;
   logic [31:0] m_fault_pc;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      mq.delete();
      m_pc       = RST_PC;
      m_mode     = M_RUN;
      m_fault_pc = 32'd0;
   endtask

   // One clock of the model, using the inputs that will be seen at the next edge.
   task automatic model_step();
      if (mq.size() != 0 && out_ready) void'(mq.pop_front());
      if (m_mode != M_FAULT && redirect_valid) begin
         mq.delete();
         if (redirect_pc % 4 != 0) begin
            m_mode     = M_FAULT;
            m_fault_pc = redirect_pc;
         end else begin
            m_pc   = redirect_pc;
            m_mode = halt_req ? M_HALT : M_RUN;
         end
      end else if (m_mode == M_RUN && !halt_req) begin
         if (mq.size() < 2) begin
            if (m_pc >= 4 * DEPTH) begin
               m_mode     = M_FAULT;
               m_fault_pc = m_pc;
            end else begin
               mq.push_back('{pc: m_pc, instr: rom[m_pc / 4]});
               m_pc = m_pc + 32'd4;
            end
         end
      end else if (m_mode == M_RUN && halt_req) begin
         m_mode = M_HALT;
      end else if (m_mode == M_HALT && !halt_req) begin
         m_mode = M_RUN;
      end
   endtask

   task automatic check_outputs();
      chk("out_valid", 32'(out_valid), 32'(mq.size() != 0));
      chk("imem_addr", imem_addr, m_pc);
      chk("halted", 32'(halted), 32'(m_mode == M_HALT && mq.size() == 0));
      chk("fault", 32'(fault), 32'(m_mode == M_FAULT));
      chk("fault_pc", fault_pc, m_fault_pc);
      if (mq.size() != 0) begin
         chk("out_pc", out_pc, mq[0].pc);
         chk("out_instr", out_instr, mq[0].instr);
      end
   endtask

   // Called #1 after a rising edge; drives inputs, advances model, checks after next edge.
   task automatic cycle(input logic rdy, input logic rv, input logic [31:0] rpc, input logic hr);
      out_ready      = rdy;
      redirect_valid = rv;
      redirect_pc    = rpc;
      halt_req       = hr;
      model_step();
      @(posedge clk);
      #1;
      check_outputs();
   endtask

   task automatic do_reset();
      redirect_valid = 1'b0;
      halt_req       = 1'b0;
      rst_n          = 1'b0;
      #2;
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_imem_addr", imem_addr, RST_PC);
      chk("rst_halted", 32'(halted), 32'd0);
      chk("rst_fault", 32'(fault), 32'd0);
      chk("rst_fault_pc", fault_pc, 32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      model_reset();
   endtask

   initial begin
      int halt_lvl;
      for (int i = 0; i < int'(DEPTH); i++) rom[i] = $urandom;
      rom[0] = 32'h2001_0006;
      rom[1] = 32'h2002_0007;
      rom[2] = 32'h2003_0008;
      model_reset();
      @(posedge clk);
      #1;

      // Straight-line fetch with decode always ready
      do_reset();
      for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 32'd0, 1'b0);
      chk("seq_addr_after4", imem_addr, 32'h10);

      // Decode stalled: queue fills and PC holds
      do_reset();
      for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 32'd0, 1'b0);
      chk("stall_addr", imem_addr, 32'h8);
      chk("stall_head", out_pc, 32'h0);
      for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 32'd0, 1'b0);

      // Redirect while holding PC 4,8 and popping
      do_reset();
      cycle(1'b0, 1'b0, 32'd0, 1'b0);
      cycle(1'b1, 1'b0, 32'd0, 1'b0);
      cycle(1'b0, 1'b0, 32'd0, 1'b0);
      cycle(1'b1, 1'b1, 32'h4C, 1'b0);
      cycle(1'b1, 1'b0, 32'd0, 1'b0);
      chk("redir_target", out_pc, 32'h4C);
      cycle(1'b1, 1'b0, 32'd0, 1'b0);

      // Misaligned redirect, then stay frozen
      cycle(1'b1, 1'b1, 32'h4E, 1'b0);
      chk("misalign_fault_pc", fault_pc, 32'h4E);
      for (int i = 0; i < 5; i++) cycle(1'b1, i[0], 32'h80, 1'b0);

      // Last legal word then range fault
      do_reset();
      cycle(1'b1, 1'b1, 32'h3FC, 1'b0);
      for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 32'd0, 1'b0);
      chk("range_fault_pc", fault_pc, 32'h400);

      // Halt with two entries queued, then resume
      do_reset();
      cycle(1'b0, 1'b1, 32'h10, 1'b0);
      cycle(1'b0, 1'b0, 32'd0, 1'b0);
      cycle(1'b0, 1'b0, 32'd0, 1'b0);
      for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 32'd0, 1'b1);
      chk("halt_addr", imem_addr, 32'h18);
      for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 32'd0, 1'b0);

      // Random traffic
      do_reset();
      halt_lvl = 0;
      for (int n = 0; n < 3000; n++) begin
         logic        rdy, rv;
         logic [31:0] rpc;
         int          sel;
         if ($urandom_range(0, 19) == 0) halt_lvl = 1 - halt_lvl;
         rdy = ($urandom_range(0, 3) != 0);
         rv  = ($urandom_range(0, 11) == 0);
         sel = $urandom_range(0, 29);
         if (sel == 0)      rpc = ($urandom_range(0, 255) * 4) | 32'(1 + $urandom_range(0, 2));
         else if (sel < 4)  rpc = 32'h3F0 + 32'($urandom_range(0, 3) * 4);
         else if (sel == 4) rpc = 32'hFFFF_FFFC;
         else               rpc = 32'($urandom_range(0, 255) * 4);
         cycle(rdy, rv, rpc, halt_lvl[0]);
         if ((m_mode == M_FAULT && $urandom_range(0, 7) == 0) || $urandom_range(0, 299) == 0) begin
            do_reset();
            halt_lvl = 0;
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
